mult_operand_server: RTL
========================

// Module: mult_operand_server
// PURPOSE
//  Opposite end of the multiplier batch engine's operand/result protocol. Answers REQ_AB with
//  {A,B} plus a one-cycle ACK, drives START/HALT, checks every returned X/X_VALID against a
//  scoreboard of expected A*B products, and counts pass/fail. Used as on-board traffic source/checker.
// PARAMETERS
//  BATCH     8      pairs per START; equals engine input FIFO depth; power of 2, 2..256
//  NUM_BATCH 4      batches per run; total pairs = BATCH*NUM_BATCH
//  SEED_A    8'h03  initial A (8-bit up-counter, +1 per pair, wraps FF->00)
//  SEED_B    8'h01  initial B (8-bit Fibonacci LFSR, taps 8,6,5,4); 0 is replaced by 8'h01
// PORTS
//  CLK      in  1   clock, rising edge
//  RST_N    in  1   asynchronous active-low reset
//  GO       in  1   start run (sampled in IDLE or DONE)
//  ABORT    in  1   cancel run
//  REQ_AB   in  1   engine requests one operand pair
//  X        in  16  result from engine
//  X_VALID  in  1   X valid this cycle
//  A, B     out 8   operands, registered, valid while ACK=1
//  ACK      out 1   one-cycle strobe: A,B valid
//  START    out 1   kick engine
//  HALT     out 1   one-cycle abort strobe to engine
//  BUSY     out 1   run in progress
//  DONE     out 1   run finished; held until GO or reset
//  PASS_CNT out 16  matching results, saturating
//  ERR_CNT  out 16  mismatching/unexpected results, saturating
// BEHAVIOUR
//  Reset: all outputs 0; generators reloaded with seeds; scoreboard empty; state IDLE.
//  States: IDLE -> KICK (GO; counters cleared) -> FEED -> DRAIN -> KICK | DONE; DONE -GO-> KICK.
//  KICK: START=1, held until REQ_AB=1 seen, then FEED. Level hold covers engine still leaving OUTPUT.
//  FEED: if REQ_AB=1 & ACK=0 & sent<BATCH, next cycle ACK=1 with A,B = generator outputs;
//   same edge pushes A*B (16-bit unsigned) into scoreboard and advances both generators.
//   Max throughput 1 pair / 2 cycles. sent==BATCH -> DRAIN. ACK is never 1 two cycles in a row.
//  Results (any state): X_VALID=1 -> pop scoreboard; X==head -> PASS_CNT+1, else ERR_CNT+1;
//   X_VALID with empty scoreboard -> ERR_CNT+1, no pop. Counters saturate at 16'hFFFF.
//  DRAIN: rcvd==BATCH -> DONE if last batch (BUSY=0, DONE=1), else KICK with batch_cnt+1.
//  ABORT (KICK/FEED/DRAIN): HALT=1 one cycle, ACK/START forced 0, scoreboard flushed, -> IDLE;
//   counters keep values. ABORT in IDLE/DONE ignored. ABORT wins over a same-cycle ACK.
//  GO while BUSY ignored. Reset mid-run: immediate async return to reset state.
// CONFIGURATION
//  HALT_ON_ERR_EN defined: first mismatch -> HALT=1 one cycle, state ERR (BUSY=0, DONE=0,
//   ERR_CNT frozen at 1), left only by GO (restart) or reset.
//  Not defined: mismatches only counted; run continues to DONE.
// STRUCTURE
//  Package mult_srv_pkg: state encoding enum, LFSR tap constant, DATA_W=8, PROD_W=16.
//  Sub-module mult_srv_sb: synchronous FIFO, depth BATCH x 16 bit, push/pop/flush/empty/full.
//  Top: FSM, sent/rcvd/batch counters, A counter, B LFSR, result compare, stat counters.
// TESTING
//  1 BATCH=4,NUM_BATCH=1, ideal engine model; GO -> first ACK A=8'h03 B=8'h01, 4 ACKs, PASS_CNT=4, ERR_CNT=0, DONE=1.
//  2 Model flips X[0] on 2nd result; no macro -> PASS_CNT=3, ERR_CNT=1, DONE=1; with HALT_ON_ERR_EN -> HALT pulse, ERR, DONE=0.
//  3 NUM_BATCH=3,BATCH=4 -> START asserted 3 separate times, PASS_CNT=12, DONE=1.
//  4 ABORT after 2nd ACK -> HALT 1 cycle, no further ACK, BUSY=0 next cycle, scoreboard empty.
//  5 X_VALID=1, X=16'h1234 in IDLE -> ERR_CNT=1, PASS_CNT=0.
//  6 RST_N low mid-DRAIN -> all outputs 0 same cycle; GO after release restarts at A=8'h03.

Source files
------------

// File: rtl/mult_srv_pkg.sv
// Shared types and constants for the multiplier operand server and its scoreboard.
package mult_srv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PROD_W = 16;

    // Fibonacci feedback taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KICK  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } srv_state_t;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mult_srv_sb.sv
// Expected-product scoreboard: synchronous FIFO with push/pop/flush and empty/full flags.
module mult_srv_sb #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_head  = r_mem[r_rd];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/mult_operand_server.sv
// Operand source / result checker for the multiplier batch engine.
// Optional HALT_ON_ERR_EN: first mismatch during a run halts the engine and parks in ERR.
module mult_operand_server
    import mult_srv_pkg::*;
#(
    parameter int unsigned       BATCH     = 8,
    parameter int unsigned       NUM_BATCH = 4,
    parameter logic [DATA_W-1:0] SEED_A    = 8'h03,
    parameter logic [DATA_W-1:0] SEED_B    = 8'h01
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              GO,
    input  logic              ABORT,
    input  logic              REQ_AB,
    input  logic [PROD_W-1:0] X,
    input  logic              X_VALID,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              ACK,
    output logic              START,
    output logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic [PROD_W-1:0] PASS_CNT,
    output logic [PROD_W-1:0] ERR_CNT
);

    localparam int unsigned CW = $clog2(BATCH + 1);
    localparam int unsigned BW = $clog2(NUM_BATCH + 1);
    localparam logic [DATA_W-1:0] SEED_B_EFF = (SEED_B == '0) ? 8'h01 : SEED_B;

    srv_state_t        r_state;
    logic [CW-1:0]     r_sent;
    logic [CW-1:0]     r_rcvd;
    logic [BW-1:0]     r_batch;
    logic [DATA_W-1:0] r_gen_a;
    logic [DATA_W-1:0] r_gen_b;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_ack;
    logic              r_halt;
    logic [PROD_W-1:0] r_pass;
    logic [PROD_W-1:0] r_err;

    logic              w_busy;
    logic              w_go;
    logic              w_abort;
    logic              w_trip;
    logic              w_stop;
    logic              w_fire;
    logic              w_pop;
    logic              w_good;
    logic              w_bad;
    logic              w_flush;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_head;
    logic              w_sb_empty;
    logic              w_sb_full;

    assign w_busy  = (r_state == ST_KICK) | (r_state == ST_FEED) | (r_state == ST_DRAIN);
    assign w_go    = GO & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
    assign w_abort = ABORT & w_busy;
    assign w_pop   = X_VALID & ~w_sb_empty;
    assign w_good  = w_pop & (X == w_head);
    assign w_bad   = X_VALID & (w_sb_empty | (X != w_head));
`ifdef HALT_ON_ERR_EN
    assign w_trip  = w_bad & w_busy;
`else
    assign w_trip  = 1'b0;
`endif
    assign w_stop  = w_abort | w_trip;
    assign w_flush = w_stop | w_go;
    assign w_prod  = PROD_W'(r_gen_a) * PROD_W'(r_gen_b);

    // ACK-low term spaces pairs two cycles apart; a stop in the same cycle suppresses the pair
    assign w_fire = (r_state == ST_FEED) & REQ_AB & ~r_ack & (r_sent < CW'(BATCH))
                  & ~w_stop & ~w_sb_full;

    mult_srv_sb #(
        .DEPTH (BATCH),
        .W     (PROD_W)
    ) u_sb (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_fire),
        .i_data  (w_prod),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_empty (w_sb_empty),
        .o_full  (w_sb_full)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_sent  <= '0;
            r_rcvd  <= '0;
            r_batch <= '0;
            r_gen_a <= SEED_A;
            r_gen_b <= SEED_B_EFF;
            r_a     <= '0;
            r_b     <= '0;
            r_ack   <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_ack  <= w_fire;
            r_halt <= w_stop;
            if (w_fire) begin
                r_a     <= r_gen_a;
                r_b     <= r_gen_b;
                r_gen_a <= r_gen_a + 8'd1;
                r_gen_b <= lfsr_next(r_gen_b);
                r_sent  <= r_sent + CW'(1);
            end
            if (w_pop && ((r_state == ST_FEED) || (r_state == ST_DRAIN)))
                r_rcvd <= r_rcvd + CW'(1);
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (GO) begin
                        r_state <= ST_KICK;
                        r_batch <= '0;
                    end
                end
                ST_KICK: begin
                    r_sent <= '0;
                    r_rcvd <= '0;
                    if (REQ_AB) r_state <= ST_FEED;
                end
                ST_FEED: begin
                    if (r_sent == CW'(BATCH)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_rcvd == CW'(BATCH)) begin
                        if (r_batch == BW'(NUM_BATCH - 1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_KICK;
                            r_batch <= r_batch + BW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_abort)     r_state <= ST_IDLE;
            else if (w_trip) r_state <= ST_ERR;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pass <= '0;
            r_err  <= '0;
        end else if (w_go) begin
            r_pass <= '0;
            r_err  <= '0;
        end else if (r_state != ST_ERR) begin
            if (w_good && (r_pass != '1)) r_pass <= r_pass + 16'd1;
            if (w_bad  && (r_err  != '1)) r_err  <= r_err  + 16'd1;
        end
    end

    assign A        = r_a;
    assign B        = r_b;
    assign ACK      = r_ack;
    assign HALT     = r_halt;
    assign START    = (r_state == ST_KICK) & ~ABORT;
    assign BUSY     = w_busy;
    assign DONE     = (r_state == ST_DONE);
    assign PASS_CNT = r_pass;
    assign ERR_CNT  = r_err;

endmodule
